// File: rtl/clock_divider_bank.sv
// clock_divider_bank: N_CH independent programmable clock dividers.
// Each channel counts enabled cycles from 0 to act_div. At terminal count it
// emits a one-cycle tick and toggles a 50%-duty divided clock. New divisors
// are staged as pending and applied only at a period boundary, so a divisor
// change never produces a runt or stretched period.
// Valid/ready: no handshake here. cfg_wr is a one-cycle fire-and-forget strobe
// that is always accepted. cfg_err answers one cycle later when the channel
// does not exist.
module clock_divider_bank #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 26,
    parameter int CH_W    = 2,
    parameter int DEF_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   en,
    input  logic              sync_clr,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   clk_div,
    output logic              cfg_err
);

    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
    localparam logic [CH_W:0]    N_CH_V    = (CH_W+1)'(N_CH);

    // Compared one bit wider so that N_CH == 2**CH_W is representable.
    logic cfg_ch_ok;
    assign cfg_ch_ok = ({1'b0, cfg_ch} < N_CH_V);

    // A write to a channel that does not exist is flagged for one cycle and touches no state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ch_ok;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] act_q;
        logic [CNT_W-1:0] act_d;
        logic [CNT_W-1:0] pend_q;
        logic [CNT_W-1:0] pend_d;
        logic             pend_v_q;
        logic             pend_v_d;
        logic             tick_q;
        logic             tick_d;
        logic             clk_div_q;
        logic             clk_div_d;
        logic             wr_hit;
        logic             term;

        assign wr_hit = cfg_wr && cfg_ch_ok && (cfg_ch == CH_W'(i));
        assign term   = (cnt_q == act_q);

        // Next-state logic, in priority order: sync_clr, disabled, terminal count, count.
        // The pending divisor consumed here is the one held before this edge, so a
        // write in the same cycle always lands in pend and waits for a later boundary.
        always_comb begin
            cnt_d     = cnt_q;
            act_d     = act_q;
            pend_d    = pend_q;
            pend_v_d  = pend_v_q;
            tick_d    = 1'b0;
            clk_div_d = clk_div_q;

            if (sync_clr) begin
                cnt_d     = '0;
                clk_div_d = 1'b0;
                if (pend_v_q) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                end
            end else if (!en[i]) begin
                // An idle channel has no period to protect, so it adopts
                // the new divisor at once and restarts its phase.
                if (pend_v_q) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                    cnt_d    = '0;
                end
            end else if (term) begin
                cnt_d     = '0;
                clk_div_d = ~clk_div_q;
                tick_d    = 1'b1;
                if (pend_v_q) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (wr_hit) begin
                pend_d   = cfg_div;
                pend_v_d = 1'b1;
            end
        end

        // Channel state register. Reset drops any pending write and restarts the phase.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q     <= '0;
                act_q     <= DEF_DIV_V;
                pend_q    <= DEF_DIV_V;
                pend_v_q  <= 1'b0;
                tick_q    <= 1'b0;
                clk_div_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                act_q     <= act_d;
                pend_q    <= pend_d;
                pend_v_q  <= pend_v_d;
                tick_q    <= tick_d;
                clk_div_q <= clk_div_d;
            end
        end

        assign tick[i]    = tick_q;
        assign clk_div[i] = clk_div_q;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed scenarios plus a random stretch, checked
// cycle by cycle against a behavioural channel model through an expected queue.
module tb_clock_divider_bank;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 26;
    localparam int CH_W    = 3;
    localparam int DEF_DIV = 4;
    localparam int W       = 2 * N_CH + 1;
    localparam int HIST    = 64;

    logic              clk;
    logic              reset;
    logic [N_CH-1:0]   en;
    logic              sync_clr;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [N_CH-1:0]   tick;
    logic [N_CH-1:0]   clk_div;
    logic              cfg_err;

    clock_divider_bank #(
        .N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEF_DIV(DEF_DIV)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .tick(tick), .clk_div(clk_div), .cfg_err(cfg_err)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int n_vec;
    int n_err;
    int n_edge;
    logic [N_CH-1:0] h_tk  [HIST];
    logic [N_CH-1:0] h_ck  [HIST];
    logic            h_err [HIST];

    // reference model state
    int              m_cnt  [N_CH];
    int              m_act  [N_CH];
    int              m_pend [N_CH];
    logic            m_pv   [N_CH];
    logic [N_CH-1:0] m_ck;
    logic [N_CH-1:0] m_tk;
    logic            m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c]  = 0;
            m_act[c]  = DEF_DIV;
            m_pend[c] = DEF_DIV;
            m_pv[c]   = 1'b0;
        end
        m_ck  = '0;
        m_tk  = '0;
        m_err = 1'b0;
    endtask

    // One edge of the model, driven by the inputs presented before that edge.
    task automatic model_step();
        for (int c = 0; c < N_CH; c++) begin
            m_tk[c] = 1'b0;
            if (sync_clr) begin
                m_cnt[c] = 0;
                m_ck[c]  = 1'b0;
                if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 1'b0; end
            end else if (!en[c]) begin
                if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 1'b0; m_cnt[c] = 0; end
            end else if (m_cnt[c] == m_act[c]) begin
                m_cnt[c] = 0;
                m_ck[c]  = ~m_ck[c];
                m_tk[c]  = 1'b1;
                if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 1'b0; end
            end else begin
                m_cnt[c] = m_cnt[c] + 1;
            end
            if (cfg_wr && int'(cfg_ch) == c) begin
                m_pend[c] = int'(cfg_div);
                m_pv[c]   = 1'b1;
            end
        end
        m_err = cfg_wr && (int'(cfg_ch) >= N_CH);
    endtask

    // Drive one edge: predict, push, clock, pop and compare at the falling edge.
    task automatic step();
        logic [W-1:0] got;
        logic [W-1:0] exp;
        model_step();
        exp_q.push_back({m_err, m_ck, m_tk});
        @(posedge clk);
        @(negedge clk);
        n_edge++;
        got = {cfg_err, clk_div, tick};
        exp = exp_q.pop_front();
        check($sformatf("sb_e%0d", n_edge), 32'(got), 32'(exp));
        if (n_edge < HIST) begin
            h_tk[n_edge]  = tick;
            h_ck[n_edge]  = clk_div;
            h_err[n_edge] = cfg_err;
        end
    endtask

    task automatic idle(input int n);
        cfg_wr   = 1'b0;
        sync_clr = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_cfg(input int ch, input int div);
        sync_clr = 1'b0;
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(div);
        step();
        cfg_wr   = 1'b0;
    endtask

    // Called at a falling edge; the first rising edge after return is edge 1.
    task automatic do_reset();
        reset    = 1'b0;
        cfg_wr   = 1'b0;
        sync_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        n_edge = 0;
    endtask

    function automatic int tick_count(input int ch, input int from, input int upto);
        int s = 0;
        for (int e = from; e <= upto; e++) s += int'(h_tk[e][ch]);
        return s;
    endfunction

    initial begin
        n_vec    = 0;
        n_err    = 0;
        n_edge   = 0;
        reset    = 1'b0;
        en       = '0;
        sync_clr = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({cfg_err, clk_div, tick}), 32'(0));

        // Default divisor from reset release: ticks at edges 5, 10, 15.
        en = '1;
        reset  = 1'b1;
        n_edge = 0;
        idle(16);
        check("s1_tick_e4",  32'(h_tk[4][0]),  32'(0));
        check("s1_tick_e5",  32'(h_tk[5][0]),  32'(1));
        check("s1_tick_e6",  32'(h_tk[6][0]),  32'(0));
        check("s1_tick_e10", 32'(h_tk[10][0]), 32'(1));
        check("s1_tick_e15", 32'(h_tk[15][0]), 32'(1));
        check("s1_ck_e4",    32'(h_ck[4][0]),  32'(0));
        check("s1_ck_e5",    32'(h_ck[5][0]),  32'(1));
        check("s1_ck_e9",    32'(h_ck[9][0]),  32'(1));
        check("s1_ck_e10",   32'(h_ck[10][0]), 32'(0));

        // Divisor change mid-period waits for the period boundary.
        do_reset();
        en = '1;
        idle(2);
        write_cfg(1, 9);
        idle(30);
        check("s2_tick_e5",   32'(h_tk[5][1]),  32'(1));
        check("s2_no_short",  32'(tick_count(1, 6, 14)), 32'(0));
        check("s2_tick_e15",  32'(h_tk[15][1]), 32'(1));
        check("s2_tick_e25",  32'(h_tk[25][1]), 32'(1));
        check("s2_ch0_e10",   32'(h_tk[10][0]), 32'(1));

        // Disabled channel adopts div=0 immediately, then runs at clk/2.
        do_reset();
        en = 4'b1011;
        write_cfg(2, 0);
        idle(1);
        en = '1;
        idle(6);
        check("s3_ticks", 32'(tick_count(2, 3, 8)), 32'(6));
        check("s3_ck_e3", 32'(h_ck[3][2]), 32'(1));
        check("s3_ck_e4", 32'(h_ck[4][2]), 32'(0));
        check("s3_ck_e5", 32'(h_ck[5][2]), 32'(1));

        // Write to a nonexistent channel: error pulse, no aliasing onto ch1.
        do_reset();
        en = '1;
        write_cfg(5, 0);
        idle(10);
        check("s4_err_e1",  32'(h_err[1]), 32'(1));
        check("s4_err_e2",  32'(h_err[2]), 32'(0));
        check("s4_ch1_e3",  32'(tick_count(1, 2, 4)), 32'(0));
        check("s4_ch1_e5",  32'(h_tk[5][1]),  32'(1));
        check("s4_ch1_e10", 32'(h_tk[10][1]), 32'(1));

        // Staggered phases, then sync_clr realigns every channel.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            en = N_CH'($urandom_range(0, 15));
            idle(1);
        end
        en = '1;
        sync_clr = 1'b1;
        step();
        idle(6);
        check("s5_ck_clr",   32'(h_ck[13]), 32'(0));
        check("s5_tk_clr",   32'(h_tk[13]), 32'(0));
        check("s5_quiet",    32'(h_tk[14] | h_tk[15] | h_tk[16] | h_tk[17]), 32'(0));
        check("s5_together", 32'(h_tk[18]), 32'(4'hF));

        // Asynchronous reset mid-period with a pending divisor.
        do_reset();
        en = '1;
        idle(5);
        write_cfg(0, 9);
        idle(1);
        check("s6_ck_before", 32'(h_ck[7][0]), 32'(1));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("s6_async_out", 32'({cfg_err, clk_div, tick}), 32'(0));
        @(negedge clk);
        reset  = 1'b1;
        n_edge = 0;
        idle(12);
        check("s6_tick_e5",  32'(h_tk[5][0]),  32'(1));
        check("s6_tick_e10", 32'(h_tk[10][0]), 32'(1));
        check("s6_ck_e5",    32'(h_ck[5][0]),  32'(1));

        // Random stretch: enables, writes (some to bad channels), sync_clr collisions.
        do_reset();
        en = '1;
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(0, 15)) : '1;
            cfg_wr   = ($urandom_range(0, 5) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 7));
            cfg_div  = CNT_W'($urandom_range(0, 6));
            sync_clr = ($urandom_range(0, 24) == 0);
            step();
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- N_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, counter and divisor width in bits.
- CH_W, 2, channel-select width; 2^CH_W >= N_CH.
- DEF_DIV, 4, divisor loaded into every channel at reset; must be < 2^CNT_W.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  N_CH  per-channel count enable.
- sync_clr  in  1  synchronous phase-align clear of all channels.
- cfg_wr  in  1  one-cycle divisor write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  CNT_W  new divisor value.
- tick  out  N_CH  per-channel one-cycle pulse at terminal count.
- clk_div  out  N_CH  per-channel 50%-duty divided square wave.
- cfg_err  out  1  one-cycle pulse flagging a write to a nonexistent channel.

Function
REQ-003 Each channel SHALL hold a counter cnt, an active divisor act_div, a pending divisor pend_div and a pending flag pend_v; all outputs SHALL be registered.
REQ-004 When en[i]=1 and cnt==act_div at a rising edge, channel i SHALL set cnt to 0, toggle clk_div[i] and assert tick[i] for exactly one cycle.
REQ-005 When en[i]=1 and cnt!=act_div, the channel SHALL increment cnt and drive tick[i]=0.
REQ-006 The tick period SHALL be act_div+1 enabled cycles and the clk_div period SHALL be 2*(act_div+1) cycles.
REQ-007 act_div=0 SHALL assert tick every enabled cycle and toggle clk_div every cycle (clk/2).
REQ-008 When en[i]=0, the channel SHALL hold cnt and clk_div[i] and drive tick[i]=0.
REQ-009 A cfg_wr with cfg_ch<N_CH SHALL write pend_div=cfg_div and set pend_v=1, overwriting any earlier pending value.
REQ-010 A cfg_wr with cfg_ch>=N_CH SHALL change no state and SHALL pulse cfg_err for one cycle.
REQ-011 A pending divisor SHALL be applied (act_div<=pend_div, pend_v<=0) only at that channel's terminal-count edge, so that no runt or stretched period occurs.
REQ-012 A pending divisor on a channel with en=0 SHALL be applied on the next edge and SHALL also clear cnt to 0.
REQ-013 sync_clr=1 SHALL, on the next edge, set every cnt=0, clk_div=0 and tick=0, and apply every pending divisor; sync_clr SHALL take priority over terminal count and over en.
REQ-014 A cfg_wr in the same cycle as sync_clr SHALL be stored as pending and SHALL NOT be applied by that sync_clr.
REQ-015 A cfg_wr in the same cycle as a terminal count on the target channel SHALL become pending and take effect at the following terminal count.
REQ-016 Counters SHALL never exceed act_div while enabled and SHALL never wrap modulo 2^CNT_W.
REQ-017 Channels SHALL be fully independent except for sync_clr and the shared configuration port.

Reset
REQ-018 reset=0 SHALL asynchronously force cnt=0, act_div=DEF_DIV, pend_div=DEF_DIV, pend_v=0, tick=0, clk_div=0 and cfg_err=0.
REQ-019 Deassertion of reset SHALL be followed by normal operation from the first rising edge at which reset=1.
REQ-020 Reset asserted mid-period SHALL discard any pending write and restart all phases at zero.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios, one per line: stimulus -> required response.
- Defaults, en=all 1 from reset release -> tick[0] on edges 5, 10, 15; clk_div[0] high from edge 5 to edge 10 (period 10).
- Enabled ch1, cfg_wr ch1 div=9 mid-period -> current 5-cycle period completes, then ticks every 10 cycles; no short period.
- en[2]=0, then cfg_wr ch2 div=0, then en[2]=1 -> tick[2] every cycle; clk_div[2] toggles every cycle.
- cfg_wr with cfg_ch=5 and N_CH=4 -> cfg_err pulses for 1 cycle; all divisors unchanged.
- Channels staggered, then sync_clr pulse -> all clk_div=0 and cnt=0; all channels tick together 5 cycles later.
- reset=0 asserted asynchronously mid-period with a pending div -> outputs 0 immediately; after release, DEF_DIV period resumes.
